// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write-port arbiter in front of a sync FIFO
//
// Shares one FIFO write port between NUM_REQ valid/ready producers. One
// producer owns the port at a time for up to MAX_BURST beats; one idle
// cycle always separates consecutive grants.
//
// Optional build macro: FIFO_ARB_STAT_EN adds per-requester beat counters.
//
// Ports:
//   clk        clock, rising edge
//   rstn       asynchronous active-low reset
//   req_valid  per-requester data valid
//   req_data   flattened data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  per-requester accept (one-hot or zero)
//   fifo_ful   FIFO full flag
//   fifo_wr    FIFO write strobe
//   fifo_din   FIFO write data
//   grant_vld  high while a requester owns the port
//   grant_id   index of current owner
//   stat_clr   (FIFO_ARB_STAT_EN) synchronous clear of all counters
//   stat_cnt   (FIFO_ARB_STAT_EN) 16-bit saturating beat count per requester

`timescale 1ns/1ps

module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 4,
    parameter int BURST_BIT  = 3,
    parameter int ID_BIT     = 2
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_ful,
    output logic                          fifo_wr,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic                          grant_vld,
    output logic [ID_BIT-1:0]             grant_id
`ifdef FIFO_ARB_STAT_EN
    ,
    input  logic                          stat_clr,
    output logic [NUM_REQ*16-1:0]         stat_cnt
`endif
);

    localparam logic [BURST_BIT-1:0] LAST_BEAT = BURST_BIT'(MAX_BURST - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                state;
    logic [ID_BIT-1:0]     owner;
    logic [ID_BIT-1:0]     rr_ptr;
    logic [BURST_BIT-1:0]  burst_cnt;

    logic                  pick_found;
    logic [ID_BIT-1:0]     pick_id;
    logic [ID_BIT-1:0]     owner_next;
    logic                  owner_valid;
    logic                  busy;

    // Cyclic search starting at rr_ptr. Iterating from the far end toward
    // rr_ptr lets the closest valid requester overwrite the pick last.
    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req_valid[idx]) begin
                pick_found = 1'b1;
                pick_id    = ID_BIT'(idx);
            end
        end
    end

    assign owner_next  = (owner == ID_BIT'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign owner_valid = req_valid[owner];
    assign busy        = (state == BUSY);

    // Port-side outputs are combinational on registered state so fifo_ful
    // stalls the very beat it coincides with.
    assign fifo_wr   = busy & owner_valid & ~fifo_ful;
    assign req_ready = (busy & ~fifo_ful) ? (NUM_REQ'(1) << owner) : '0;
    assign fifo_din  = busy ? req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign grant_vld = busy;
    assign grant_id  = busy ? owner : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        owner     <= pick_id;
                        burst_cnt <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    // An owner that drops valid releases even while stalled.
                    if (!owner_valid) begin
                        state  <= IDLE;
                        rr_ptr <= owner_next;
                    end else if (fifo_wr) begin
                        if (burst_cnt == LAST_BEAT) begin
                            state     <= IDLE;
                            rr_ptr    <= owner_next;
                            burst_cnt <= '0;
                        end else begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FIFO_ARB_STAT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_cnt <= '0;
        end else begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (stat_clr) begin
                    stat_cnt[r*16 +: 16] <= 16'h0000;
                end else if (fifo_wr && (owner == ID_BIT'(r)) &&
                             (stat_cnt[r*16 +: 16] != 16'hFFFF)) begin
                    stat_cnt[r*16 +: 16] <= stat_cnt[r*16 +: 16] + 16'h0001;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter

`timescale 1ns/1ps

module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              rstn;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              fifo_ful;
    logic              fifo_wr;
    logic [DW-1:0]     fifo_din;
    logic              grant_vld;
    logic [1:0]        grant_id;
`ifdef FIFO_ARB_STAT_EN
    logic              stat_clr;
    logic [N*16-1:0]   stat_cnt;
`endif

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .BURST_BIT(3), .ID_BIT(2)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .fifo_ful(fifo_ful), .fifo_wr(fifo_wr), .fifo_din(fifo_din),
        .grant_vld(grant_vld), .grant_id(grant_id)
`ifdef FIFO_ARB_STAT_EN
        , .stat_clr(stat_clr), .stat_cnt(stat_cnt)
`endif
    );

    int checks = 0;
    int passes = 0;

    // Reference model: owner is -1 when nobody holds the port.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_beats = 0;
    int m_stat [N];

    logic [DW-1:0] wrlog [$];
    logic [3:0]    trace [$];
    logic [3:0]    exp_tr [$];

    typedef struct {
        logic [3:0]  v;
        logic [15:0] d;
        logic        ful;
        logic [3:0]  rdy;
        logic        wr;
        logic [15:0] din;
        logic        gv;
        logic [1:0]  gid;
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [23:0] dut_out();
        return {req_ready, fifo_wr, fifo_din, grant_vld, grant_id};
    endfunction

    function automatic logic [23:0] model_out();
        logic [3:0]  rdy;
        logic        wr;
        logic [15:0] din;
        if (m_owner < 0) return 24'h0;
        rdy = fifo_ful ? 4'h0 : 4'(1 << m_owner);
        wr  = req_valid[m_owner] & ~fifo_ful;
        din = req_data[m_owner*DW +: DW];
        return {rdy, wr, din, 1'b1, 2'(m_owner)};
    endfunction

    function automatic logic [63:0] model_stat();
        logic [63:0] s;
        s = '0;
        for (int r = 0; r < N; r++) s[r*16 +: 16] = 16'(m_stat[r]);
        return s;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_beats = 0;
        for (int r = 0; r < N; r++) m_stat[r] = 0;
    endtask

    // Advance the model across one rising edge using the inputs that were
    // presented during the cycle.
    task automatic model_step();
        bit wrote;
        wrote = 0;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (req_valid[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_beats = 0;
                    break;
                end
            end
        end else if (!req_valid[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else if (!fifo_ful) begin
            wrote = 1;
`ifdef FIFO_ARB_STAT_EN
            if (!stat_clr && m_stat[m_owner] < 65535) m_stat[m_owner]++;
`endif
            m_beats++;
            if (m_beats == MB) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
`ifdef FIFO_ARB_STAT_EN
        if (stat_clr) for (int r = 0; r < N; r++) m_stat[r] = 0;
`endif
    endtask

    task automatic cyc(input string name);
        #1;
        check(name, dut_out(), model_out());
`ifdef FIFO_ARB_STAT_EN
        check({name, "_stat"}, stat_cnt, model_stat());
`endif
        trace.push_back({grant_vld, grant_id, fifo_wr});
        if (fifo_wr) wrlog.push_back(fifo_din);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        req_valid = '0;
        req_data  = '0;
        fifo_ful  = 1'b0;
`ifdef FIFO_ARB_STAT_EN
        stat_clr  = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        model_reset();
        wrlog.delete();
        trace.delete();
        exp_tr.delete();
        rstn = 1'b1;
    endtask

    task automatic check_trace(input string name);
        int errs;
        errs = (trace.size() == exp_tr.size()) ? 0 : 1000;
        for (int i = 0; i < exp_tr.size() && i < trace.size(); i++)
            if (trace[i] !== exp_tr[i]) errs++;
        check(name, 64'(errs), 64'd0);
    endtask

    task automatic push_exp(input logic gv, input logic [1:0] gid, input logic wr, input int n);
        for (int i = 0; i < n; i++) exp_tr.push_back({gv, gid, wr});
    endtask

    initial begin
        // Test 1: reset with all requesters valid, then first grant and async abort.
        rstn      = 1'b0;
        req_valid = 4'hF;
        req_data  = 64'h4444_3333_2222_1111;
        fifo_ful  = 1'b0;
`ifdef FIFO_ARB_STAT_EN
        stat_clr  = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        #1;
        check("t1_reset_outs", dut_out(), 24'h0);
        model_reset();
        rstn = 1'b1;
        cyc("t1_idle");
        check("t1_first_grant", {grant_vld, grant_id}, {1'b1, 2'd0});
        cyc("t1_beat");
        rstn = 1'b0;
        #1;
        check("t1_async_abort", dut_out(), 24'h0);
        model_reset();

        // Test 2: single requester 2, table-driven.
        tbl[0] = '{4'b0100, 16'd1, 1'b0, 4'b0000, 1'b0, 16'd0, 1'b0, 2'd0};
        tbl[1] = '{4'b0100, 16'd1, 1'b0, 4'b0100, 1'b1, 16'd1, 1'b1, 2'd2};
        tbl[2] = '{4'b0100, 16'd2, 1'b0, 4'b0100, 1'b1, 16'd2, 1'b1, 2'd2};
        tbl[3] = '{4'b0100, 16'd3, 1'b0, 4'b0100, 1'b1, 16'd3, 1'b1, 2'd2};
        tbl[4] = '{4'b0100, 16'd4, 1'b0, 4'b0100, 1'b1, 16'd4, 1'b1, 2'd2};
        tbl[5] = '{4'b0100, 16'd5, 1'b0, 4'b0000, 1'b0, 16'd0, 1'b0, 2'd0};
        tbl[6] = '{4'b0100, 16'd5, 1'b0, 4'b0100, 1'b1, 16'd5, 1'b1, 2'd2};
        tbl[7] = '{4'b0100, 16'd6, 1'b0, 4'b0100, 1'b1, 16'd6, 1'b1, 2'd2};
        tbl[8] = '{4'b0000, 16'd6, 1'b0, 4'b0100, 1'b0, 16'd6, 1'b1, 2'd2};
        tbl[9] = '{4'b0000, 16'd0, 1'b0, 4'b0000, 1'b0, 16'd0, 1'b0, 2'd0};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            req_valid = tbl[i].v;
            req_data  = {16'h0, tbl[i].d, 16'h0, 16'h0};
            fifo_ful  = tbl[i].ful;
            #1;
            check($sformatf("t2_row%0d", i), dut_out(),
                  {tbl[i].rdy, tbl[i].wr, tbl[i].din, tbl[i].gv, tbl[i].gid});
            cyc("t2_model");
        end
        check("t2_fifo_count", 64'(wrlog.size()), 64'd6);
        for (int i = 0; i < wrlog.size() && i < 6; i++)
            check($sformatf("t2_fifo_order%0d", i), 64'(wrlog[i]), 64'(i + 1));

        // Test 3: all valid, rotation 0,1,2,3,0 with one bubble between grants.
        do_reset();
        req_valid = 4'hF;
        for (int i = 0; i < 26; i++) begin
            req_data = {$urandom, $urandom};
            cyc("t3_model");
        end
        push_exp(0, 0, 0, 1);
        for (int g = 0; g < 5; g++) begin
            push_exp(1, 2'(g % N), 1, MB);
            push_exp(0, 0, 0, 1);
        end
        check_trace("t3_rotation");

        // Test 4: owner 1 stalled by fifo_ful for 3 cycles after 2 beats.
        do_reset();
        req_valid = 4'b0010;
        req_data  = 64'h0000_0000_00A1_0000;
        for (int i = 0; i < 3; i++) cyc("t4_model");
        fifo_ful = 1'b1;
        for (int i = 0; i < 3; i++) cyc("t4_stall");
        fifo_ful = 1'b0;
        for (int i = 0; i < 3; i++) cyc("t4_model");
        push_exp(0, 0, 0, 1);
        push_exp(1, 1, 1, 2);
        push_exp(1, 1, 0, 3);
        push_exp(1, 1, 1, 2);
        push_exp(0, 0, 0, 1);
        check_trace("t4_stall_trace");

        // Test 5: owner 3 drops valid after one beat; requester 0 next.
        do_reset();
        req_valid = 4'b1000;
        req_data  = 64'hB003_0000_0000_B000;
        cyc("t5_model");
        cyc("t5_model");
        req_valid = 4'b0001;
        for (int i = 0; i < 3; i++) cyc("t5_model");
        push_exp(0, 0, 0, 1);
        push_exp(1, 3, 1, 1);
        push_exp(1, 3, 0, 1);
        push_exp(0, 0, 0, 1);
        push_exp(1, 0, 1, 1);
        check_trace("t5_release");

`ifdef FIFO_ARB_STAT_EN
        // Test 6: five beats from requester 1, then clear.
        do_reset();
        req_valid = 4'b0010;
        req_data  = 64'h0000_0000_0C01_0000;
        for (int i = 0; i < 7; i++) cyc("t6_model");
        req_valid = 4'b0000;
        cyc("t6_model");
        check("t6_stat_before", 64'(stat_cnt[31:16]), 64'd5);
        stat_clr = 1'b1;
        cyc("t6_clr");
        stat_clr = 1'b0;
        #1;
        check("t6_stat_after", 64'(stat_cnt[31:16]), 64'd0);
`endif

        // Randomized run against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            req_valid = 4'($urandom);
            req_data  = {$urandom, $urandom};
            fifo_ful  = ($urandom_range(0, 3) == 0);
`ifdef FIFO_ARB_STAT_EN
            stat_clr  = ($urandom_range(0, 63) == 0);
`endif
            cyc("rand");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one synchronous FIFO between NUM_REQ producers.
- Each producer presents a valid/ready stream. The arbiter grants one producer at a time for a bounded burst and drives the FIFO write port (fifo_wr, fifo_din).
- It honours fifo_ful as backpressure. It sits directly in front of the team's sync FIFO write interface.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 16, data width; equals the FIFO's FIFO_WIDTH
MAX_BURST, 4, max beats per grant (1..2^BURST_BIT-1)
BURST_BIT, 3, burst counter width
ID_BIT, 2, requester index width; 2^ID_BIT >= NUM_REQ

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester data valid
req_data  input  NUM_REQ*DATA_WIDTH  flattened data; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NUM_REQ  per-requester accept, one-hot or zero
fifo_ful  input  1  FIFO full flag, high active
fifo_wr  output  1  FIFO write strobe
fifo_din  output  DATA_WIDTH  FIFO write data
grant_vld  output  1  high while a requester owns the port
grant_id  output  ID_BIT  index of current owner

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk. On reset:
  - state=IDLE, owner=0, rr_ptr=0, burst_cnt=0.
  - Outputs: req_ready=0, fifo_wr=0, fifo_din=0, grant_vld=0, grant_id=0.
  - Reset mid-burst aborts the burst immediately; the beat in flight is not written.
- State IDLE:
  - All outputs are 0.
  - At a posedge with any req_valid: owner latches the first requester with valid=1, searching cyclically from rr_ptr upward. burst_cnt<=0; go to BUSY.
  - Arbitration latency is 1 cycle from valid to grant.
- State BUSY (combinational outputs from registered state):
  - grant_vld=1, grant_id=owner.
  - req_ready[owner]=!fifo_ful; all other req_ready bits are 0.
  - fifo_wr=req_valid[owner] & !fifo_ful.
  - fifo_din=req_data[owner] whenever BUSY; 0 in IDLE.
  - A beat transfers at a posedge where fifo_wr=1; burst_cnt increments by 1.
- Release (BUSY -> IDLE at that posedge; rr_ptr <= (owner+1) mod NUM_REQ):
  - (a) a beat transfers and burst_cnt==MAX_BURST-1; or
  - (b) req_valid[owner]==0 at the posedge (owner idle), regardless of fifo_ful.
- Handoff: one IDLE bubble cycle always separates two grants. Peak throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- fifo_ful=1 while BUSY:
  - No write occurs and burst_cnt holds.
  - The grant is held indefinitely while req_valid[owner] stays 1; there is no timeout.
- Writes are blocked whenever fifo_ful=1, even if the FIFO is read in the same cycle. This is conservative; no overflow is possible.
- Requester contract: req_data must be stable while req_valid=1 and req_ready=0. A requester must not drop valid without a transfer unless abandoning its request.
- Requester indices >= NUM_REQ never win arbitration.
- rr_ptr wraps from NUM_REQ-1 to 0.
- burst_cnt arithmetic is unsigned, BURST_BIT wide. It never exceeds MAX_BURST-1.

Optional Feature:
- FIFO_ARB_STAT_EN defined:
  - Adds input stat_clr (1 bit) and output stat_cnt (NUM_REQ*16).
  - stat_cnt holds one 16-bit counter per requester, counting transferred beats; each counter saturates at 16'hFFFF.
  - stat_clr=1 at a posedge zeroes all counters; clear wins over a same-cycle increment.
  - Counters reset to 0.
- Not defined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset: hold rstn=0 with req_valid=4'hF -> all outputs 0. First grant after release is grant_id=0, one cycle after rstn rises.
2. Single requester 2, valid held for 6 beats, data 0x0001..0x0006 -> 4 beats written, 1 bubble, regrant to id 2, 2 beats. FIFO contents 0x0001..0x0006 in order.
3. req_valid=4'hF continuously, FIFO never full -> grant_id sequence 0,1,2,3,0, 4 beats each, with fifo_wr low exactly one cycle between grants.
4. Owner 1 mid-burst after 2 beats, fifo_ful=1 for 3 cycles -> fifo_wr=0 and req_ready=0 for 3 cycles, grant_vld stays 1. Burst then completes 2 more beats (4 total).
5. Owner 3 drops valid after 1 beat while requester 0 is valid -> release at that edge, rr_ptr=0, next grant_id=0 after the bubble.
6. With FIFO_ARB_STAT_EN: 5 beats from requester 1, then stat_clr pulse -> stat_cnt[31:16]=5 before the pulse, 0 after. Without the macro, the same bench compiles minus the stat checks.
